// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: hex decode, frame-synchronous shadow update,
// PWM brightness, leading-zero blanking and configurable pin polarities.
module seven_seg_scan_driver #(
   parameter int unsigned DIGITS            = 4,
   parameter int unsigned SLOT_LOG2         = 14,
   parameter int unsigned BRIGHT_W          = 4,
   parameter bit          ANODE_ACTIVE_HIGH = 1'b1,
   parameter bit          SEG_ACTIVE_LOW    = 1'b1,
   parameter bit          BLANK_LEADING     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic [BRIGHT_W-1:0]   brightness,
   input  logic                  enable,
   output logic [DIGITS-1:0]     anodes,
   output logic [7:0]            segments,
   output logic                  frame_tick
);

   localparam int unsigned       IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_DIGIT = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] ANODES_OFF = {DIGITS{~ANODE_ACTIVE_HIGH}};
   localparam logic [7:0]        SEGS_OFF   = {8{SEG_ACTIVE_LOW}};

   logic [SLOT_LOG2-1:0] prescaler_q, prescaler_d;
   logic [IDX_W-1:0]     digit_q, digit_d;
   logic                 frame_tick_q, frame_tick_d;
   logic                 load_pending_q, load_pending_d;
   logic [4*DIGITS-1:0]  shadow_value_q, shadow_value_d;
   logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
   logic [DIGITS-1:0]    anodes_q, anodes_d;
   logic [7:0]           segments_q, segments_d;

   logic slot_end, frame_end, capture;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler_q    <= '0;
         digit_q        <= '0;
         frame_tick_q   <= 1'b0;
         load_pending_q <= 1'b0;
         shadow_value_q <= '0;
         shadow_dp_q    <= '0;
         anodes_q       <= ANODES_OFF;
         segments_q     <= SEGS_OFF;
      end else begin
         prescaler_q    <= prescaler_d;
         digit_q        <= digit_d;
         frame_tick_q   <= frame_tick_d;
         load_pending_q <= load_pending_d;
         shadow_value_q <= shadow_value_d;
         shadow_dp_q    <= shadow_dp_d;
         anodes_q       <= anodes_d;
         segments_q     <= segments_d;
      end
   end

   // Scan counters and frame-synchronous shadow capture.
   always_comb begin
      slot_end     = &prescaler_q;
      frame_end    = slot_end && (digit_q == LAST_DIGIT);
      prescaler_d  = prescaler_q + 1'b1;
      digit_d      = digit_q;
      if (slot_end) begin
         digit_d = frame_end ? '0 : digit_q + 1'b1;
      end
      frame_tick_d   = frame_end;
      capture        = frame_end && (load_pending_q || load);
      shadow_value_d = capture ? value_in : shadow_value_q;
      shadow_dp_d    = capture ? dp_in : shadow_dp_q;
      load_pending_d = capture ? 1'b0 : (load_pending_q || load);
   end

   logic [3:0]        cur_nibble;
   logic              cur_dp, cur_blank, upper_zero, lit;
   logic [7:0]        seg_raw;
   logic [DIGITS-1:0] anode_raw;

   // Output register inputs, derived from the current index and prescaler.
   always_comb begin
      cur_nibble = shadow_value_q[3:0];
      cur_dp     = shadow_dp_q[0];
      cur_blank  = 1'b0;
      upper_zero = 1'b1;
      // Walk from the most significant digit so upper_zero covers digits i..DIGITS-1.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (shadow_value_q[4*i +: 4] == 4'h0);
         if (digit_q == IDX_W'(i)) begin
            cur_nibble = shadow_value_q[4*i +: 4];
            cur_dp     = shadow_dp_q[i];
            cur_blank  = BLANK_LEADING && (i != 0) && upper_zero;
         end
      end
      seg_raw    = {cur_dp, cur_blank ? 7'h00 : hex7(cur_nibble)};
      lit        = enable && ((&brightness) ||
                              (prescaler_q[SLOT_LOG2-1 -: BRIGHT_W] < brightness));
      anode_raw  = lit ? (DIGITS'(1) << digit_q) : '0;
      anodes_d   = ANODE_ACTIVE_HIGH ? anode_raw : ~anode_raw;
      segments_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
   end

   assign anodes     = anodes_q;
   assign segments   = segments_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed and random stimulus checked every cycle against a
// time-based model (slot/digit derived from the cycle count since reset release).
module tb_seven_seg_scan_driver;

   localparam int DIG   = 4;
   localparam int SL    = 4;
   localparam int BW    = 4;
   localparam int SLOT  = 1 << SL;
   localparam int FRAME = SLOT * DIG;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [4*DIG-1:0]  value_in = '0;
   logic [DIG-1:0]    dp_in = '0;
   logic              load = 1'b0;
   logic [BW-1:0]     brightness = 4'hF;
   logic              enable = 1'b1;
   logic [DIG-1:0]    anodes;
   logic [7:0]        segments;
   logic              frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned cnt = 0;
   bit          pend = 0;
   logic [15:0] sh_val = '0;
   logic [3:0]  sh_dp = '0;

   seven_seg_scan_driver #(
      .DIGITS    (DIG),
      .SLOT_LOG2 (SL),
      .BRIGHT_W  (BW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .load       (load),
      .brightness (brightness),
      .enable     (enable),
      .anodes     (anodes),
      .segments   (segments),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cnt);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("reset_anodes", 8'(anodes), 8'h00);
      chk("reset_segments", segments, 8'hFF);
      chk("reset_frame_tick", 8'(frame_tick), 8'h00);
   endtask

   // One clock: predict what the edge produces from the model state and current inputs.
   task automatic cyc();
      int         pre, dig;
      logic [3:0] e_an, nib;
      logic [7:0] e_seg;
      logic       e_ft, blank;
      @(posedge clk);
      pre   = int'(cnt % SLOT);
      dig   = int'((cnt / SLOT) % DIG);
      e_an  = (enable && (brightness == 4'hF || pre < int'(brightness))) ? 4'(1 << dig) : 4'h0;
      nib   = sh_val[dig*4 +: 4];
      blank = (dig > 0) && ((sh_val >> (4 * dig)) == 16'h0);
      e_seg = ~{sh_dp[dig], blank ? 7'h00 : HEX[nib]};
      e_ft  = (cnt % FRAME) == FRAME - 1;
      if (e_ft && (pend || load)) begin
         sh_val = value_in;
         sh_dp  = dp_in;
         pend   = 0;
      end else if (load) begin
         pend = 1;
      end
      cnt++;
      #1;
      chk("anodes", 8'(anodes), 8'(e_an));
      chk("segments", segments, e_seg);
      chk("frame_tick", 8'(frame_tick), 8'(e_ft));
      chk("onehot", 8'($countones(anodes) <= 1), 8'h01);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Advance until the next edge will be the one taken with frame phase ph.
   task automatic run_to(input int ph);
      while (int'(cnt % FRAME) != ph) cyc();
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      value_in = v;
      dp_in    = d;
      load     = 1'b1;
      cyc();
      load     = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cnt = 0; pend = 0; sh_val = '0; sh_dp = '0;
   endtask

   initial begin
      // Power-on reset
      #1 reset_n = 1'b0;
      #1 chk_reset_outputs();
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs();
      release_reset();

      // Idle display: "0" on digit 0, others blanked
      run(2 * FRAME);

      // Mid-frame load; shadow must not change before frame start
      run_to(20);
      pulse_load(16'h0A05, 4'b0010);
      run(2 * FRAME);

      // Two loads in one frame coalesce; value held until frame start
      run_to(5);
      pulse_load(16'h1111, 4'b0001);
      run(7);
      pulse_load(16'h2222, 4'b1000);
      run_to(0);
      run(3);
      value_in = 16'h7777;   // no load: must not be captured
      run(2 * FRAME);

      // Load on the capture cycle itself
      run_to(FRAME - 1);
      pulse_load(16'hBEEF, 4'b0101);
      run(FRAME + 5);

      // Brightness sweep
      brightness = 4'h4; run(FRAME);
      brightness = 4'h0; run(FRAME);
      brightness = 4'hF; run(FRAME);
      brightness = 4'h1; run(FRAME);

      // Enable dropped for 10 clocks mid-slot
      run_to(SLOT + 5);
      enable = 1'b0; run(10);
      enable = 1'b1; run(FRAME);

      // Randomised stretch
      for (int i = 0; i < 1500; i++) begin
         load = ($urandom_range(0, 9) == 0);
         if (load || $urandom_range(0, 3) == 0) begin
            value_in = 16'($urandom);
            if ($urandom_range(0, 1) == 0) value_in[15:8] = 8'h00;
            dp_in = 4'($urandom);
         end
         if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
         if ($urandom_range(0, 29) == 0) enable = ~enable;
         cyc();
      end
      load = 1'b0; enable = 1'b1; brightness = 4'hF;
      run(FRAME);

      // Asynchronous reset mid-slot with a load pending
      run_to(SLOT + 3);
      pulse_load(16'h4321, 4'b1111);
      run(2);
      #3 reset_n = 1'b0;
      #1 chk_reset_outputs();
      @(posedge clk);
      #1 chk_reset_outputs();
      release_reset();
      run(2 * FRAME);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
